// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared types and constants for the RV32M multiply/divide unit.
//            XLEN          - operand/result width (32 only)
//            mdu_op_e      - RV32M funct3 encodings
//            mdu_state_e   - sequencer states
//            DIV0_Q        - quotient returned on divide by zero
//            INT_MIN       - most negative signed value (overflow operand/result)
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_step
// Purpose  : One combinational restoring-division step on magnitudes.
// Ports    : rem_in       - current partial remainder (XLEN+1 bits)
//            divisor      - divisor magnitude
//            dividend_bit - next dividend bit shifted into the remainder
//            rem_out      - updated partial remainder
//            q_bit        - quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    // One extra bit above the remainder so the subtraction borrow is visible.
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[XLEN+1];
    rem_out = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
  end

endmodule : mdu_div_step
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Iterative RV32M multiply/divide unit with fixed XLEN+1 latency.
//            Radix-2 shift-add multiply and restoring divide on operand
//            magnitudes, sign correction and special cases resolved in FIN.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start         - request, sampled only in IDLE
//            op            - RV32M funct3
//            a, b          - rs1 / rs2 operands
//            kill          - abort the operation in flight
//            busy          - operation in flight (pipeline stall)
//            done          - one-cycle completion pulse
//            result        - result, valid with done and held until next done
// Revision : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  mdu_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] result_q;

  // ---------------------------------------------------------------- decode
  mdu_op_e         op_in;
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            neg_in;

  always_comb begin
    op_in = mdu_op_e'(op);
    sgn_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
            (op_in == OP_DIV)  || (op_in == OP_REM);
    sgn_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg_a = sgn_a & a[XLEN-1];
    neg_b = sgn_b & b[XLEN-1];
    abs_a = neg_a ? -a : a;
    abs_b = neg_b ? -b : b;
    if (op_in == OP_REM)
      neg_in = neg_a;                               // remainder follows dividend
    else if (op_in == OP_DIV)
      neg_in = (neg_a ^ neg_b) & (b != '0);
    else
      neg_in = neg_a ^ neg_b;                       // 0 for every unsigned op
  end

  // -------------------------------------------------------- multiply step
  // Multiplier sits in the low half of prod and is consumed LSB first while
  // partial sums accumulate in the high half.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nxt;

  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
    prod_nxt = {mul_sum, prod[XLEN-1:1]};
  end

  // ---------------------------------------------------------- divide step
  // quo starts as the dividend magnitude; its MSB feeds the remainder and
  // quotient bits fill in from the LSB.
  logic [XLEN:0] div_rem;
  logic          div_q;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (rem),
    .divisor      (mag_b),
    .dividend_bit (quo[XLEN-1]),
    .rem_out      (div_rem),
    .q_bit        (div_q)
  );

  // ------------------------------------------------------ final selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  logic              div_zero, ovf;

  always_comb begin
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -quo : quo;
    rem_fix  = neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    div_zero = (b_q == '0);
    ovf      = (a_q == XLEN'(INT_MIN)) && (b_q == '1);
    fin_res  = '0;
    case (op_q)
      OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:  fin_res = div_zero ? XLEN'(DIV0_Q) : (ovf ? XLEN'(INT_MIN) : quo_fix);
      OP_DIVU: fin_res = div_zero ? XLEN'(DIV0_Q) : quo_fix;
      OP_REM:  fin_res = div_zero ? a_q : (ovf ? '0 : rem_fix);
      OP_REMU: fin_res = div_zero ? a_q : rem_fix;
      default: fin_res = '0;
    endcase
  end

  // ------------------------------------------------------------ sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !kill) state_nxt = CALC;
      CALC:    if (kill) state_nxt = IDLE;
               else if (cnt == CW'(XLEN-1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            op_q  <= op_in;
            a_q   <= a;
            b_q   <= b;
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= neg_in;
            prod  <= {{XLEN{1'b0}}, abs_b};
            rem   <= '0;
            quo   <= abs_a;
            cnt   <= '0;
          end
        end
        CALC: begin
          prod <= prod_nxt;
          rem  <= div_rem;
          quo  <= {quo[XLEN-2:0], div_q};
          cnt  <= cnt + 1'b1;
        end
        FIN: begin
          if (!kill) result_q <= fin_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN) && !kill;
  // During the done cycle the freshly selected value is forwarded so it is
  // readable alongside done; afterwards the registered copy holds it.
  assign result = done ? fin_res : result_q;

endmodule : mdu
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu: directed cases, kill/reset
//            behaviour and randomized operations against a 64-bit arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          vectors;
  int          miscompares;
  logic [31:0] last_res;

  mdu #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy, ux, uy, q;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sx / sy; return q[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        q = ux / uy; return q[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = sx % sy; return q[31:0];
      end
      default: begin
        if (y == 0) return x;
        q = ux % uy; return q[31:0];
      end
    endcase
  endfunction

  // Issue one operation in the current cycle (cycle 0) and check busy/done
  // in every cycle up to the one after completion. A nonzero extra_cyc
  // raises a second start in that cycle, which must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int extra_cyc);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    for (int c = 1; c <= 33; c++) begin
      start = (c == extra_cyc);
      chk("busy_calc", {31'b0, busy}, 32'd1);
      chk("done_pulse", {31'b0, done}, (c == 33) ? 32'd1 : 32'd0);
      if (c == 33) chk("result_at_done", result, exp);
      tick();
    end
    start = 1'b0;
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("done_after", {31'b0, done}, 32'd0);
    chk("result_hold", result, exp);
    last_res = exp;
  endtask

  initial begin
    vectors = 0; miscompares = 0; last_res = '0;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; kill = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);

    // Directed cases
    run_op(OP_MUL,    32'd10,        32'd16,        32'd160,       5);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        0);
    run_op(OP_REMU,   32'd100,       32'd7,         32'd2,         0);
    run_op(OP_DIV,    32'h1234,      32'd0,         32'hFFFF_FFFF, 0);
    run_op(OP_REMU,   32'h1234,      32'd0,         32'h1234,      0);
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0);

    // start together with kill in IDLE is ignored
    op = OP_MUL; a = 32'd2; b = 32'd2; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("kill_start_idle_busy", {31'b0, busy}, 32'd0);

    // kill at cycle 12 of a DIVU
    op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    chk("pre_kill_busy", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    chk("kill_cycle_done", {31'b0, done}, 32'd0);
    tick();
    kill = 1'b0;
    chk("post_kill_busy", {31'b0, busy}, 32'd0);
    chk("post_kill_done", {31'b0, done}, 32'd0);
    chk("post_kill_result", result, last_res);
    run_op(OP_MUL, 32'd3, 32'd5, 32'd15, 0);

    // rst at cycle 20 of an operation
    op = OP_MULHU; a = $urandom; b = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    last_res = '0;

    // Randomized operations, biased toward the special cases
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      int          sel;
      ro  = 3'($urandom_range(0, 7));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'd0;
      else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 2) ry = 32'($urandom_range(1, 20));
      else if (sel == 3) ry = -32'($urandom_range(1, 20));
      run_op(ro, rx, ry, model(ro, rx, ry), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mdu
`default_nettype wire
